// File: rtl/pixel_write_port.sv
// Pixel write port: queues plot requests in a small FIFO and drains them into a
// framebuffer write port. Off-screen pixels are dropped and counted.
module pixel_write_port #(
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter int DEPTH    = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        plot,
   input  logic [8:0]  x,
   input  logic [8:0]  y,
   input  logic [5:0]  colour,
   output logic        ready,
   input  logic        fb_ready,
   output logic        fb_we,
   output logic [16:0] fb_addr,
   output logic [5:0]  fb_data,
   output logic        busy,
   output logic [7:0]  clip_count
);

   // state | meaning
   // IDLE  | FIFO empty, no write pending
   // ISSUE | FIFO non-empty, head popped whenever fb_ready is high
   typedef enum logic {IDLE, ISSUE} state_t;

   localparam int          AW     = $clog2(DEPTH);
   localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
   localparam logic [9:0]  W_LIM  = 10'(SCREEN_W);
   localparam logic [9:0]  H_LIM  = 10'(SCREEN_H);

   state_t          state_q, state_d;
   logic [AW:0]     count_q, count_d;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [23:0]     mem [DEPTH];
   logic            fb_we_q, fb_we_d;
   logic [16:0]     fb_addr_q, fb_addr_d;
   logic [5:0]      fb_data_q, fb_data_d;
   logic [7:0]      clip_q, clip_d;

   logic            push, pop, on_screen;
   logic [8:0]      head_x, head_y;
   logic [5:0]      head_c;
   logic [16:0]     addr_calc;

   // Full blocks a push even when a pop happens on the same edge.
   assign ready     = (count_q != FULL);
   assign push      = plot && ready;
   assign pop       = (state_q == ISSUE) && fb_ready;

   assign head_x    = mem[rd_ptr_q][23:15];
   assign head_y    = mem[rd_ptr_q][14:6];
   assign head_c    = mem[rd_ptr_q][5:0];
   assign on_screen = ({1'b0, head_x} < W_LIM) && ({1'b0, head_y} < H_LIM);
   assign addr_calc = 17'(head_y) * 17'(SCREEN_W) + 17'(head_x);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      fb_we_d   = 1'b0;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      clip_d    = clip_q;

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE:  if (push) state_d = ISSUE;
         ISSUE: if (pop && !push && (count_q == (AW+1)'(1))) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (pop) begin
         if (on_screen) begin
            fb_we_d   = 1'b1;
            fb_addr_d = addr_calc;
            fb_data_d = head_c;
         end else if (clip_q != 8'hFF) begin
            clip_d = clip_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
         clip_q    <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         fb_we_q   <= fb_we_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
         clip_q    <= clip_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {x, y, colour};
   end

   assign fb_we      = fb_we_q;
   assign fb_addr    = fb_addr_q;
   assign fb_data    = fb_data_q;
   assign clip_count = clip_q;
   assign busy       = (count_q != '0) || fb_we_q;

endmodule
